keypad_uart_tx: RTL and testbench

KEYPAD_UART_TX -- requirements
Module: keypad_uart_tx

---
 rtl/keypad_uart_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_uart_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_uart_tx.sv
// keypad_uart_tx
//   Turns keypad key events into UART frames. A level request on TxD_start is
//   synchronised, edge-detected and turned into exactly one byte push into a
//   small FIFO. A transmitter drains the FIFO back-to-back, LSB first, with a
//   start bit and a stop bit on every frame.
//
//   Build option: define KEYPAD_UART_TX_PARITY_EN to insert an even-parity bit
//   between the data bits and the stop bit (8E1, 11-bit frame). Without it the
//   frame is 8N1 (10 bits) and no parity logic exists.
//
// Parameters
//   CLK_HZ      input clock frequency in Hz
//   BAUD        serial bit rate; each bit lasts floor(CLK_HZ/BAUD) clocks
//   FIFO_DEPTH  byte queue depth, power of two in 2..16
//
// Ports
//   FPGA_CLK1_50  in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   TxD_start     in   key-event request (level, asynchronous)
//   TxD_data      in   [7:0] key code, stable while TxD_start is high
//   TxD           out  serial line, idle high, registered
//   TxD_busy      out  frame on the line or bytes still queued
//   fifo_full     out  FIFO holds FIFO_DEPTH bytes
//   overflow      out  one-cycle pulse when a request is dropped
module keypad_uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       FPGA_CLK1_50,
  input  logic       reset_n,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int BAUD_W   = $clog2(BAUD_DIV);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef KEYPAD_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------------------------------------------------------------
  // Request synchroniser and rising-edge detector
  // ---------------------------------------------------------------------
  logic [1:0] sync_reg;      // [0] metastability flop, [1] clean sample
  logic       start_prev_reg;
  logic [1:0] sync_vld_reg;  // tracks when sync_reg[1] holds a real sample
  logic       armed_reg;     // set once a genuine low has been seen
  logic       rise;

  // After reset the synchroniser reads 0 regardless of the pin, so an edge
  // is only believed once a real low has passed through it. This keeps a
  // request held high across reset release from producing a push.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg       <= '0;
      start_prev_reg <= 1'b0;
      sync_vld_reg   <= '0;
      armed_reg      <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[0], TxD_start};
      start_prev_reg <= sync_reg[1];
      sync_vld_reg   <= {sync_vld_reg[0], 1'b1};
      if (sync_vld_reg[1] && !sync_reg[1])
        armed_reg <= 1'b1;
    end
  end

  assign rise = armed_reg & sync_reg[1] & ~start_prev_reg;

  // ---------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;
  logic [7:0]       pop_data;

  state_t           state_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;
  logic             baud_tick;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FIFO_FULL_CNT);
  assign baud_tick  = (baud_cnt_reg == BAUD_LAST);
  assign pop_data   = mem[rd_ptr_reg];

  // The transmitter takes a byte either when idle or exactly at the end of
  // a stop bit. A pop frees a slot in the same cycle, so a push to a full
  // FIFO that coincides with a pop is accepted.
  assign pop     = ~fifo_empty & ((state_reg == IDLE) | ((state_reg == STOP) & baud_tick));
  assign push_ok = rise & (~fifo_full | pop);

  always_ff @(posedge FPGA_CLK1_50) begin
    if (push_ok)
      mem[wr_ptr_reg] <= TxD_data;
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= rise & ~push_ok;
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
`ifdef KEYPAD_UART_TX_PARITY_EN
  logic parity_reg;
`endif

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
`ifdef KEYPAD_UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      // Bit timer restarts at every bit boundary and rests at 0 in IDLE.
      if (state_reg == IDLE || baud_tick)
        baud_cnt_reg <= '0;
      else
        baud_cnt_reg <= baud_cnt_reg + 1'b1;

      if (pop) begin
        // Load the next byte and drive the start bit on the same edge.
        state_reg   <= START;
        shift_reg   <= pop_data;
        bit_cnt_reg <= '0;
        tx_reg      <= 1'b0;
`ifdef KEYPAD_UART_TX_PARITY_EN
        parity_reg  <= ^pop_data;
`endif
      end else begin
        case (state_reg)
          IDLE: tx_reg <= 1'b1;
          START: begin
            if (baud_tick) begin
              state_reg <= DATA;
              tx_reg    <= shift_reg[0];
            end
          end
          DATA: begin
            if (baud_tick) begin
              if (bit_cnt_reg == 3'd7) begin
`ifdef KEYPAD_UART_TX_PARITY_EN
                state_reg <= PARITY;
                tx_reg    <= parity_reg;
`else
                state_reg <= STOP;
                tx_reg    <= 1'b1;
`endif
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                shift_reg   <= {1'b0, shift_reg[7:1]};
                tx_reg      <= shift_reg[1];
              end
            end
          end
`ifdef KEYPAD_UART_TX_PARITY_EN
          PARITY: begin
            if (baud_tick) begin
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end
          end
`endif
          STOP: begin
            // Reaching here with a tick means the FIFO was empty.
            if (baud_tick) begin
              state_reg <= IDLE;
              tx_reg    <= 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign TxD      = tx_reg;
  assign TxD_busy = (state_reg != IDLE) | ~fifo_empty;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_keypad_uart_tx.sv
// Testbench for keypad_uart_tx at default parameters. A frame monitor checks
// every frame on TxD against a byte queue holding what should be sent next;
// the stimulus block pushes key codes and updates that queue by the FIFO's
// acceptance rule, then checks flags, latencies and frame spacing.
module tb_keypad_uart_tx;

  localparam int BIT_CLKS = 50000000 / 115200;
  localparam int DEPTH    = 4;
`ifdef KEYPAD_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * BIT_CLKS;

  logic       FPGA_CLK1_50 = 1'b0;
  logic       reset_n      = 1'b0;
  logic       TxD_start    = 1'b0;
  logic [7:0] TxD_data     = 8'h00;
  logic       TxD;
  logic       TxD_busy;
  logic       fifo_full;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ovf_cycles  = 0;
  int frames_done = 0;
  bit mon_busy    = 1'b0;

  logic [7:0] model_q[$];  // bytes pushed and accepted, not yet on the line
  int         starts[$];   // cycle of each observed start bit

  keypad_uart_tx dut (
    .FPGA_CLK1_50 (FPGA_CLK1_50),
    .reset_n      (reset_n),
    .TxD_start    (TxD_start),
    .TxD_data     (TxD_data),
    .TxD          (TxD),
    .TxD_busy     (TxD_busy),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  always #10 FPGA_CLK1_50 = ~FPGA_CLK1_50;

  always @(negedge FPGA_CLK1_50) cyc <= cyc + 1;
  always @(negedge FPGA_CLK1_50) if (overflow === 1'b1) ovf_cycles <= ovf_cycles + 1;

  initial begin
    #1700000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge FPGA_CLK1_50);
    #1;
  endtask

  function automatic logic expected_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == NBITS - 1) return 1'b1;
    return 1'($countones(b) % 2);  // even parity bit
  endfunction

  // Frame monitor: on each start bit, check the first and last clock of
  // every bit period against the byte at the head of the expected queue.
  always begin
    step();
    if (reset_n === 1'b1 && TxD === 1'b0) begin
      logic [7:0] b;
      bit         aborted;
      int         fno;
      aborted  = 1'b0;
      mon_busy = 1'b1;
      starts.push_back(cyc);
      fno = starts.size() - 1;
      if (model_q.size() == 0) begin
        chk($sformatf("unexpected_frame%0d", fno), 32'd1, 32'd0);
        b = 8'h00;
      end else begin
        b = model_q.pop_front();
      end
      for (int i = 0; i < NBITS && !aborted; i++) begin
        for (int j = 0; j < BIT_CLKS && !aborted; j++) begin
          if (i != 0 || j != 0) step();
          if (reset_n !== 1'b1) aborted = 1'b1;
          else if (j == 0 || j == BIT_CLKS - 1)
            chk($sformatf("frame%0d_byte%02h_bit%0d_%s", fno, b, i, (j == 0) ? "first" : "last"),
                32'(TxD), 32'(expected_bit(b, i)));
        end
      end
      if (!aborted) frames_done++;
      mon_busy = 1'b0;
    end
  end

  task automatic push_now(input logic [7:0] d, input int width, input bit at_pop);
    TxD_data  = d;
    TxD_start = 1'b1;
    if (at_pop || model_q.size() < DEPTH) model_q.push_back(d);
    repeat (width) step();
    TxD_start = 1'b0;
  endtask

  task automatic wait_until_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_start(input string tag, input int n, output int k);
    int t = 0;
    while (starts.size() <= n && t < 60) begin step(); t++; end
    chk({tag, "_start_timeout"}, 32'(starts.size() <= n), 32'd0);
    k = (starts.size() > n) ? starts[n] : cyc;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int t = 0;
    while ((model_q.size() != 0 || mon_busy || TxD_busy !== 1'b0) && t < limit) begin
      step();
      t++;
    end
    chk({tag, "_idle_timeout"}, 32'(t >= limit), 32'd0);
  endtask

  initial begin
    int         s, k, n0, o0, f0;
    logic [7:0] r;

    // Reset values
    repeat (3) step();
    chk("rst_TxD", 32'(TxD), 32'd1);
    chk("rst_busy", 32'(TxD_busy), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    repeat (6) step();

    // Single 0x35 frame: latency, bit sequence, busy falling after stop
    n0 = starts.size();
    s  = cyc;
    push_now(8'h35, 3, 1'b0);
    wait_start("A", n0, k);
    chk("A_latency", 32'(k - s), 32'd4);
    chk("A_busy_in_frame", 32'(TxD_busy), 32'd1);
    wait_until_cyc(k + FRAME_CLKS - 1);
    chk("A_busy_last_stop", 32'(TxD_busy), 32'd1);
    step();
    chk("A_busy_after_stop", 32'(TxD_busy), 32'd0);
    chk("A_TxD_idle", 32'(TxD), 32'd1);

    // 0x07 (odd number of ones)
    repeat (5) step();
    push_now(8'h07, 1, 1'b0);
    wait_idle("B07", FRAME_CLKS + 50);

    // Request held high far longer than a frame: exactly one frame
    repeat (5) step();
    n0 = starts.size();
    o0 = ovf_cycles;
    push_now(8'h41, 6000, 1'b0);
    repeat (10) step();
    chk("hold_frames", 32'(starts.size() - n0), 32'd1);
    chk("hold_overflow", 32'(ovf_cycles - o0), 32'd0);
    chk("hold_busy", 32'(TxD_busy), 32'd0);

    // Burst: fill FIFO during a frame, drop one, then push at the pop edge
    repeat (5) step();
    n0 = starts.size();
    f0 = frames_done;
    push_now(8'h31, 2, 1'b0);
    wait_start("C", n0, k);
    wait_until_cyc(k + 500);
    for (int d = 8'h32; d <= 8'h35; d++) begin
      push_now(8'(d), 1 + $urandom_range(0, 20), 1'b0);
      repeat (5) step();
      chk($sformatf("C_full_after_%02h", d), 32'(fifo_full), 32'(model_q.size() == DEPTH));
    end
    o0 = ovf_cycles;
    push_now(8'h36, 1 + $urandom_range(0, 20), 1'b0);
    repeat (5) step();
    chk("C_drop_overflow_pulse", 32'(ovf_cycles - o0), 32'd1);
    chk("C_full_after_drop", 32'(fifo_full), 32'd1);
    // Push timed so its write lands on the stop-end pop of the first frame
    wait_until_cyc(k + FRAME_CLKS - 3);
    o0 = ovf_cycles;
    push_now(8'h37, 1, 1'b1);
    repeat (5) step();
    chk("C_race_overflow", 32'(ovf_cycles - o0), 32'd0);
    chk("C_race_full", 32'(fifo_full), 32'd1);
    wait_idle("C", 6 * FRAME_CLKS);
    chk("C_frames", 32'(frames_done - f0), 32'd6);
    for (int i = 0; i < 5; i++)
      if (starts.size() > n0 + i + 1)
        chk($sformatf("C_gap%0d", i), 32'(starts[n0+i+1] - starts[n0+i]), 32'(FRAME_CLKS));

    // Reset mid-frame at bit 4 with two bytes queued
    repeat (5) step();
    n0 = starts.size();
    f0 = frames_done;
    r  = 8'($urandom_range(0, 255)) & 8'hF7;  // data bit 3 low: line is low at bit 4
    push_now(r, 2, 1'b0);
    wait_start("D", n0, k);
    wait_until_cyc(k + 200);
    push_now(8'($urandom_range(0, 255)), 2, 1'b0);
    repeat (5) step();
    push_now(8'($urandom_range(0, 255)), 2, 1'b0);
    wait_until_cyc(k + 4 * BIT_CLKS + 100);
    chk("D_line_low_before_reset", 32'(TxD), 32'd0);
    #4;
    reset_n   = 1'b0;
    TxD_data  = 8'($urandom_range(0, 255));
    TxD_start = 1'b1;  // held high across reset release
    #1;
    chk("D_rst_TxD", 32'(TxD), 32'd1);
    chk("D_rst_busy", 32'(TxD_busy), 32'd0);
    chk("D_rst_full", 32'(fifo_full), 32'd0);
    model_q.delete();
    repeat (3) step();
    #4;
    reset_n = 1'b1;
    repeat (30) step();
    chk("D_held_no_frame", 32'(starts.size() - n0), 32'd1);
    chk("D_held_busy", 32'(TxD_busy), 32'd0);
    chk("D_aborted_frame", 32'(frames_done - f0), 32'd0);
    TxD_start = 1'b0;
    repeat (10) step();
    chk("D_after_fall_busy", 32'(TxD_busy), 32'd0);
    n0 = starts.size();
    s  = cyc;
    push_now(8'($urandom_range(0, 255)), 4, 1'b0);
    wait_start("D2", n0, k);
    chk("D2_latency", 32'(k - s), 32'd4);
    wait_idle("D2", FRAME_CLKS + 50);

    // Random bytes pushed while idle: one on the line, two queued
    repeat (5) step();
    n0 = starts.size();
    for (int i = 0; i < 3; i++) begin
      push_now(8'($urandom_range(0, 255)), 1 + $urandom_range(0, 4), 1'b0);
      repeat (8) step();
    end
    chk("E_full", 32'(fifo_full), 32'd0);
    chk("E_busy", 32'(TxD_busy), 32'd1);
    wait_idle("E", 3 * FRAME_CLKS + 100);
    chk("E_frames", 32'(starts.size() - n0), 32'd3);
    for (int i = 0; i < 2; i++)
      if (starts.size() > n0 + i + 1)
        chk($sformatf("E_gap%0d", i), 32'(starts[n0+i+1] - starts[n0+i]), 32'(FRAME_CLKS));
    chk("end_TxD", 32'(TxD), 32'd1);
    chk("end_overflow_total", 32'(ovf_cycles), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
